// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter feeding a shared two-stage SECDED Hamming encoder (pack, then encode).
// Optional one-shot bit-flip injection on the encode stage is enabled by defining HAMMING_ARB_ERR_INJ_EN.
module hamming_enc_arbiter #(
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned NUM_REQ     = 4,
    localparam int unsigned ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
    localparam int unsigned CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1,
    localparam int unsigned ID_WIDTH    = $clog2(NUM_REQ),
    localparam int unsigned POS_WIDTH   = $clog2(CODED_WIDTH)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [CODED_WIDTH-1:0]        out_data_o,
    output logic [ID_WIDTH-1:0]           out_id_o
`ifdef HAMMING_ARB_ERR_INJ_EN
    ,
    input  logic                          err_inj_i,
    input  logic [POS_WIDTH-1:0]          err_pos_i
`endif
);

    localparam int unsigned CNT_W = ID_WIDTH + 1;

    logic                   s1_valid;
    logic [CODED_WIDTH-1:0] s1_word;
    logic [ID_WIDTH-1:0]    s1_id;
    logic                   s2_valid;
    logic [CODED_WIDTH-1:0] s2_word;
    logic [ID_WIDTH-1:0]    s2_id;
    logic [ID_WIDTH-1:0]    rr_ptr;

    logic [NUM_REQ-1:0]     rot_valid;
    logic [CNT_W-1:0]       win_sum;
    logic [ID_WIDTH-1:0]    winner;
    logic [ID_WIDTH-1:0]    rr_next;
    logic                   grant_any;
    logic                   s1_room;
    logic                   s1_load;
    logic                   s2_load;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [DATA_WIDTH-1:0]  pack_rem;
    logic [CODED_WIDTH-1:0] pad_word;
    logic [CODED_WIDTH-1:0] code_word;
    logic                   par_acc;
    logic [CODED_WIDTH-1:0] err_mask;

    assign s2_load = s1_valid && (!s2_valid || out_ready_i);
    assign s1_room = !s1_valid || s2_load;
    assign s1_load = grant_any && s1_room;

    // Rotate requests so the search always starts at rr_ptr, then map back to an index
    always_comb begin
        rot_valid = NUM_REQ'({req_valid_i, req_valid_i} >> rr_ptr);
        grant_any = 1'b0;
        win_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && rot_valid[i]) begin
                grant_any = 1'b1;
                win_sum   = {1'b0, rr_ptr} + CNT_W'(i);
            end
        end
        if (win_sum >= CNT_W'(NUM_REQ)) begin
            win_sum = win_sum - CNT_W'(NUM_REQ);
        end
        winner = win_sum[ID_WIDTH-1:0];
    end

    assign rr_next = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : ID_WIDTH'(winner + 1'b1);

    assign req_ready_o = (grant_any && s1_room && !rst_i) ? NUM_REQ'(1) << winner : '0;

    always_comb begin
        sel_data = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (winner == ID_WIDTH'(r)) begin
                sel_data = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Data bits fill non-power-of-two positions from 3 upward; parity slots stay zero
    always_comb begin
        pad_word = '0;
        pack_rem = sel_data;
        for (int p = 3; p < CODED_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                pad_word[p] = pack_rem[0];
                pack_rem    = pack_rem >> 1;
            end
        end
    end

    // Parity k covers every position whose index has bit k set; bit 0 closes overall parity
    always_comb begin
        code_word = s1_word;
        par_acc   = 1'b0;
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            par_acc = 1'b0;
            for (int p = 1; p < CODED_WIDTH; p++) begin
                if (((p >> k) & 1) != 0) begin
                    par_acc = par_acc ^ s1_word[p];
                end
            end
            code_word[1 << k] = par_acc;
        end
        code_word[0] = ^code_word[CODED_WIDTH-1:1];
    end

`ifdef HAMMING_ARB_ERR_INJ_EN
    logic                 err_armed;
    logic [POS_WIDTH-1:0] err_pos;

    // New arming wins over consumption; an out-of-range position is consumed without a flip
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_armed <= 1'b0;
            err_pos   <= '0;
        end else if (err_inj_i) begin
            err_armed <= 1'b1;
            err_pos   <= err_pos_i;
        end else if (s2_load) begin
            err_armed <= 1'b0;
        end
    end

    always_comb begin
        err_mask = '0;
        if (err_armed && (32'(err_pos) < CODED_WIDTH)) begin
            err_mask = CODED_WIDTH'(1) << err_pos;
        end
    end
`else
    always_comb begin
        err_mask = '0;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_word  <= '0;
            s2_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_word  <= pad_word;
                s1_id    <= winner;
                rr_ptr   <= rr_next;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_word  <= code_word ^ err_mask;
                s2_id    <= s1_id;
            end else if (out_ready_i) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid_o = s2_valid;
    assign out_data_o  = s2_word;
    assign out_id_o    = s2_id;

endmodule
